// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter of three register-file write requesters; FP doubles take two beats; macro WB_ARB_R0_PROTECT_EN suppresses integer writes to r0; ports: clk, rst, req_* (per requester), rf_* (registered write port), grant_id, busy
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*ADDR_W-1:0] req_wreg,
  input  logic [3*DATA_W-1:0] req_wdata,
  input  logic [3*DATA_W-1:0] req_wdata2,
  input  logic [2:0]          req_float,
  input  logic [2:0]          req_double,
  output logic                rf_we_int,
  output logic                rf_we_float,
  output logic [ADDR_W-1:0]   rf_wreg,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [1:0]          grant_id,
  output logic                busy
);
  localparam logic ARB  = 1'b0;
  localparam logic DBL2 = 1'b1;
  logic state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic we_int_q, we_int_d, we_float_q, we_float_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d, dbl_wreg_q, dbl_wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dbl_wdata_q, dbl_wdata_d;
  logic [1:0] gid_q, gid_d;
  logic [1:0] c1, c2, gnt;
  logic gnt_ok, protect;
  logic [ADDR_W-1:0] sel_wreg;
  always_comb begin
    c1 = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    gnt = req_valid[rr_ptr_q] ? rr_ptr_q : req_valid[c1] ? c1 : c2;
    gnt_ok = !rst && state_q == ARB && |req_valid;
    req_ready = gnt_ok ? 3'b001 << gnt : 3'b000;
    sel_wreg = req_wreg[gnt*ADDR_W +: ADDR_W];
`ifdef WB_ARB_R0_PROTECT_EN
    protect = sel_wreg == '0;
`else
    protect = 1'b0;
`endif
    state_d = ARB;
    rr_ptr_d = rr_ptr_q;
    we_int_d = 1'b0;
    we_float_d = 1'b0;
    wreg_d = wreg_q;
    wdata_d = wdata_q;
    gid_d = gid_q;
    dbl_wreg_d = dbl_wreg_q;
    dbl_wdata_d = dbl_wdata_q;
    if (state_q == DBL2) begin
      we_float_d = 1'b1;
      wreg_d = dbl_wreg_q + ADDR_W'(1);
      wdata_d = dbl_wdata_q;
    end else if (gnt_ok) begin
      rr_ptr_d = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
      gid_d = gnt;
      wreg_d = sel_wreg;
      wdata_d = req_wdata[gnt*DATA_W +: DATA_W];
      we_float_d = req_float[gnt];
      we_int_d = !req_float[gnt] && !protect;
      dbl_wreg_d = sel_wreg;
      dbl_wdata_d = req_wdata2[gnt*DATA_W +: DATA_W];
      state_d = (req_float[gnt] && req_double[gnt]) ? DBL2 : ARB;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      rr_ptr_q <= 2'd0;
      we_int_q <= 1'b0;
      we_float_q <= 1'b0;
      wreg_q <= '0;
      wdata_q <= '0;
      gid_q <= 2'd0;
      dbl_wreg_q <= '0;
      dbl_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      we_int_q <= we_int_d;
      we_float_q <= we_float_d;
      wreg_q <= wreg_d;
      wdata_q <= wdata_d;
      gid_q <= gid_d;
      dbl_wreg_q <= dbl_wreg_d;
      dbl_wdata_q <= dbl_wdata_d;
    end
  end
  assign rf_we_int = we_int_q;
  assign rf_we_float = we_float_q;
  assign rf_wreg = wreg_q;
  assign rf_wdata = wdata_q;
  assign grant_id = gid_q;
  assign busy = state_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized check of wb_arbiter against a behavioural model
module tb_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] valid = '0, flt = '0, dbl = '0, req_ready;
  logic [4:0] wreg [3];
  logic [31:0] wd [3], wd2 [3];
  logic [14:0] req_wreg;
  logic [95:0] req_wdata, req_wdata2;
  logic rf_we_int, rf_we_float, busy;
  logic [4:0] rf_wreg;
  logic [31:0] rf_wdata;
  logic [1:0] grant_id;
  int errors = 0, checks = 0;
  int ptr = 0, lg;
  bit pend = 0, prot = 0;
  logic [4:0] pend_reg;
  logic [31:0] pend_data;
  logic e_wi = 0, e_wf = 0;
  logic [4:0] e_wreg = '0;
  logic [31:0] e_wdata = '0;
  logic [1:0] e_gid = '0;
  always #5 clk = ~clk;
  assign req_wreg = {wreg[2], wreg[1], wreg[0]};
  assign req_wdata = {wd[2], wd[1], wd[0]};
  assign req_wdata2 = {wd2[2], wd2[1], wd2[0]};
  wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(req_ready),
    .req_wreg(req_wreg), .req_wdata(req_wdata), .req_wdata2(req_wdata2),
    .req_float(flt), .req_double(dbl), .rf_we_int(rf_we_int),
    .rf_we_float(rf_we_float), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input logic f, input logic d, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b);
    valid[i] = 1'b1; flt[i] = f; dbl[i] = d; wreg[i] = r; wd[i] = a; wd2[i] = b;
  endtask
  task automatic step();
    int g;
    #1;
    g = -1;
    if (!rst && !pend)
      for (int k = 0; k < 3; k++)
        if (g < 0 && valid[(ptr + k) % 3]) g = (ptr + k) % 3;
    check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("busy", busy, pend);
    @(posedge clk);
    if (rst) begin
      ptr = 0; pend = 0; e_wi = 0; e_wf = 0; e_wreg = '0; e_wdata = '0; e_gid = '0;
    end else if (pend) begin
      pend = 0; e_wi = 0; e_wf = 1; e_wreg = pend_reg + 5'd1; e_wdata = pend_data;
    end else if (g >= 0) begin
      e_gid = 2'(g); e_wreg = wreg[g]; e_wdata = wd[g];
      e_wf = flt[g]; e_wi = !flt[g] && !(prot && wreg[g] == 5'd0);
      if (flt[g] && dbl[g]) begin
        pend = 1; pend_reg = wreg[g]; pend_data = wd2[g];
      end
      ptr = (g + 1) % 3;
    end else begin
      e_wi = 0; e_wf = 0;
    end
    @(negedge clk);
    check("rf_we_int", rf_we_int, e_wi);
    check("rf_we_float", rf_we_float, e_wf);
    check("rf_wreg", rf_wreg, e_wreg);
    check("rf_wdata", rf_wdata, e_wdata);
    check("grant_id", grant_id, e_gid);
    lg = g;
    if (g >= 0) valid[g] = 1'b0;
  endtask
  initial begin
`ifdef WB_ARB_R0_PROTECT_EN
    prot = 1;
`endif
    for (int i = 0; i < 3; i++) begin
      wreg[i] = '0; wd[i] = '0; wd2[i] = '0;
    end
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 5'(i + 1), 32'h100 + i, 32'h0);
      step();
      check("rr_order", lg, c % 3);
    end
    valid = '0;
    step();
    set_req(1, 1'b1, 1'b1, 5'd4, 32'hAAAA0000, 32'h5555FFFF);
    step();
    check("dbl_beat1", {rf_we_float, rf_wreg, rf_wdata}, {1'b1, 5'd4, 32'hAAAA0000});
    set_req(0, 1'b0, 1'b0, 5'd9, 32'hC0FFEE, 32'h0);
    step();
    check("dbl_beat2", {rf_we_float, rf_wreg, rf_wdata}, {1'b1, 5'd5, 32'h5555FFFF});
    step();
    check("after_dbl", lg, 0);
    set_req(2, 1'b1, 1'b1, 5'd31, 32'h1, 32'h2);
    step(); step();
    check("wrap_reg", {rf_we_float, rf_wreg}, {1'b1, 5'd0});
    set_req(0, 1'b1, 1'b1, 5'd8, 32'h8, 32'h9);
    step();
    rst = 1'b1;
    step();
    check("rst_dbl", {rf_we_int, rf_we_float, rf_wreg, rf_wdata, grant_id, busy}, '0);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h0);
    step();
    check("r0_write", rf_we_int, !prot);
    set_req(2, 1'b0, 1'b1, 5'd7, 32'h7, 32'h77);
    set_req(1, 1'b0, 1'b0, 5'd3, 32'h3, 32'h0);
    step(); step(); step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 3; i++)
        if (!valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) : 5'($urandom),
                  $urandom, $urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
